// File: rtl/tmds_serial_tx.sv
// Single-clock TMDS transmitter: samples one RGB pixel every 10 bit clocks,
// DVI 8b/10b encodes each channel with running disparity, shifts symbols out LSB-first.
module tmds_serial_tx (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_strobe,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    output logic       tmds_b,
    output logic       tmds_g,
    output logic       tmds_r,
    output logic       tmds_clk
);

    localparam int unsigned SYM_W = 10;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned PIX_W = 8;

    localparam logic [3:0]       BIT_LAST = 4'd9;
    localparam logic [3:0]       BIT_ENC  = 4'd4;
    localparam logic [SYM_W-1:0] CTRL_00  = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01  = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10  = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11  = 10'b1010101011;
    localparam logic [SYM_W-1:0] CLK_PAT  = 10'b0000011111;

    logic [3:0]              bit_cnt_q;
    logic [PIX_W-1:0]        cap_r_q, cap_g_q, cap_b_q;
    logic                    cap_de_q, cap_hs_q, cap_vs_q;
    logic [SYM_W-1:0]        enc_r_q, enc_g_q, enc_b_q;
    logic [SYM_W-1:0]        enc_r_d, enc_g_d, enc_b_d;
    logic signed [CNT_W-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
    logic signed [CNT_W-1:0] cnt_r_d, cnt_g_d, cnt_b_d;
    logic [SYM_W-1:0]        sh_r_q, sh_g_q, sh_b_q, sh_clk_q;

    // Data-period encoder: returns {new disparity, 10-bit symbol}.
    function automatic logic [CNT_W+SYM_W-1:0] tmds_data(
        input logic [PIX_W-1:0]        d,
        input logic signed [CNT_W-1:0] cnt_in
    );
        logic [3:0]              n1d;
        logic [3:0]              n1;
        logic [8:0]              qm;
        logic signed [CNT_W-1:0] diff;
        logic signed [CNT_W-1:0] cnt_out;
        logic [SYM_W-1:0]        q;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) n1d = n1d + 4'(d[i]);
        qm[0] = d[0];
        if (n1d > 4'd4 || (n1d == 4'd4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + 4'(qm[i]);
        // diff is ones minus zeros of qm[7:0], i.e. 2*n1 - 8
        diff = $signed(5'(n1) + 5'(n1) - 5'd8);
        if (cnt_in == 5'sd0 || diff == 5'sd0) begin
            q       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_out = qm[8] ? (cnt_in + diff) : (cnt_in - diff);
        end else if ((cnt_in > 5'sd0 && diff > 5'sd0) || (cnt_in < 5'sd0 && diff < 5'sd0)) begin
            q       = {1'b1, qm[8], ~qm[7:0]};
            cnt_out = cnt_in + (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            q       = {1'b0, qm[8], qm[7:0]};
            cnt_out = cnt_in - (qm[8] ? 5'sd0 : 5'sd2) + diff;
        end
        return {cnt_out, q};
    endfunction

    function automatic logic [SYM_W-1:0] tmds_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    // Capture registers feed this logic over a 5-cycle multicycle path (capture at 9, encode at 4).
    always_comb begin
        enc_b_d = tmds_ctrl({cap_vs_q, cap_hs_q});
        enc_g_d = CTRL_00;
        enc_r_d = CTRL_00;
        cnt_b_d = '0;
        cnt_g_d = '0;
        cnt_r_d = '0;
        if (cap_de_q) begin
            {cnt_b_d, enc_b_d} = tmds_data(cap_b_q, cnt_b_q);
            {cnt_g_d, enc_g_d} = tmds_data(cap_g_q, cnt_g_q);
            {cnt_r_d, enc_r_d} = tmds_data(cap_r_q, cnt_r_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            cap_r_q   <= '0;
            cap_g_q   <= '0;
            cap_b_q   <= '0;
            cap_de_q  <= 1'b0;
            cap_hs_q  <= 1'b0;
            cap_vs_q  <= 1'b0;
            enc_r_q   <= CTRL_00;
            enc_g_q   <= CTRL_00;
            enc_b_q   <= CTRL_00;
            cnt_r_q   <= '0;
            cnt_g_q   <= '0;
            cnt_b_q   <= '0;
            sh_r_q    <= '0;
            sh_g_q    <= '0;
            sh_b_q    <= '0;
            sh_clk_q  <= '0;
        end else begin
            bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? 4'd0 : bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
                cap_r_q  <= red;
                cap_g_q  <= green;
                cap_b_q  <= blue;
                cap_de_q <= de;
                cap_hs_q <= hsync;
                cap_vs_q <= vsync;
                sh_r_q   <= enc_r_q;
                sh_g_q   <= enc_g_q;
                sh_b_q   <= enc_b_q;
                sh_clk_q <= CLK_PAT;
            end else begin
                sh_r_q   <= {1'b0, sh_r_q[SYM_W-1:1]};
                sh_g_q   <= {1'b0, sh_g_q[SYM_W-1:1]};
                sh_b_q   <= {1'b0, sh_b_q[SYM_W-1:1]};
                sh_clk_q <= {1'b0, sh_clk_q[SYM_W-1:1]};
            end
            if (bit_cnt_q == BIT_ENC) begin
                enc_r_q <= enc_r_d;
                enc_g_q <= enc_g_d;
                enc_b_q <= enc_b_d;
                cnt_r_q <= cnt_r_d;
                cnt_g_q <= cnt_g_d;
                cnt_b_q <= cnt_b_d;
            end
        end
    end

    assign pix_strobe = (bit_cnt_q == BIT_LAST);
    assign tmds_b     = sh_b_q[0];
    assign tmds_g     = sh_g_q[0];
    assign tmds_r     = sh_r_q[0];
    assign tmds_clk   = sh_clk_q[0];

endmodule

// File: tb/tb_tmds_serial_tx.sv
// Directed and random pixel streams into tmds_serial_tx; deserializes the three
// channels plus clock and compares each symbol and running disparity to expectations.
module tb_tmds_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_strobe;
    logic [7:0] red, green, blue;
    logic       de, hsync, vsync;
    logic       tmds_b, tmds_g, tmds_r, tmds_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
        logic       chk;
        logic [9:0] eb, eg, er;
        int         cb, cg, cr;
    } vec_t;

    vec_t vq[$];
    vec_t filler;
    int   mcnt[3];

    always #5 clk = ~clk;

    tmds_serial_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_strobe(pix_strobe),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .tmds_b    (tmds_b),
        .tmds_g    (tmds_g),
        .tmds_r    (tmds_r),
        .tmds_clk  (tmds_clk)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] r, g, b, input logic d, hs, vs,
                                input logic chk, input logic [9:0] eb, eg, er,
                                input int cb, cg, cr);
        vec_t v;
        v.r = r; v.g = g; v.b = b; v.de = d; v.hs = hs; v.vs = vs;
        v.chk = chk; v.eb = eb; v.eg = eg; v.er = er;
        v.cb = cb; v.cg = cg; v.cr = cr;
        return v;
    endfunction

    // Reference DVI encoder; ch selects the disparity state (0=b,1=g,2=r).
    function automatic logic [9:0] ref_enc(input int ch, input logic [7:0] d,
                                           input logic den, input logic c1, input logic c0);
        logic [8:0] qm;
        logic [9:0] q;
        int n1d, n1, n0;
        if (!den) begin
            mcnt[ch] = 0;
            case ({c1, c0})
                2'b00:   q = 10'b1101010100;
                2'b01:   q = 10'b0010101011;
                2'b10:   q = 10'b0101010100;
                default: q = 10'b1010101011;
            endcase
            return q;
        end
        n1d = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt[ch] == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            mcnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            mcnt[ch] -= (qm[8] ? 0 : 2) - (n1 - n0);
        end
        return q;
    endfunction

    task automatic drive(input vec_t v);
        red = v.r; green = v.g; blue = v.b;
        de = v.de; hsync = v.hs; vsync = v.vs;
    endtask

    task automatic garble();
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
        de = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
    endtask

    // Starts just after reset release; covers edges 1..9 and presents the first pixel.
    task automatic post_reset(input vec_t first);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq("pre_strobe", int'(pix_strobe), (k == 9) ? 1 : 0);
            check_eq("pre_out", int'({tmds_b, tmds_g, tmds_r, tmds_clk}), 0);
            if (k == 9) drive(first);
            else garble();
        end
    endtask

    // Collects one 10-bit symbol per line; presents nxt in the strobe cycle, noise elsewhere.
    task automatic do_slot(input vec_t nxt, output logic [9:0] sb, sg, sr, sc,
                           output int cb, cg, cr);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sb[i] = tmds_b; sg[i] = tmds_g; sr[i] = tmds_r; sc[i] = tmds_clk;
            if (i == 0) begin
                cb = $signed(dut.cnt_b_q);
                cg = $signed(dut.cnt_g_q);
                cr = $signed(dut.cnt_r_q);
            end
            check_eq("strobe", int'(pix_strobe), (i == 9) ? 1 : 0);
            if (i == 9) drive(nxt);
            else garble();
        end
    endtask

    task automatic run_list();
        logic [9:0] sb, sg, sr, sc, eb, eg, er;
        int cb, cg, cr, ecb, ecg, ecr;
        mcnt = '{0, 0, 0};
        post_reset(vq[0]);
        do_slot((vq.size() > 1) ? vq[1] : filler, sb, sg, sr, sc, cb, cg, cr);
        check_eq("rst_tok_b", int'(sb), 'h354);
        check_eq("rst_tok_g", int'(sg), 'h354);
        check_eq("rst_tok_r", int'(sr), 'h354);
        check_eq("clk_pat0", int'(sc), 'h01F);
        for (int j = 0; j < vq.size(); j++) begin
            do_slot((j + 2 < vq.size()) ? vq[j+2] : filler, sb, sg, sr, sc, cb, cg, cr);
            eb = ref_enc(0, vq[j].b, vq[j].de, vq[j].vs, vq[j].hs); ecb = mcnt[0];
            eg = ref_enc(1, vq[j].g, vq[j].de, 1'b0, 1'b0);         ecg = mcnt[1];
            er = ref_enc(2, vq[j].r, vq[j].de, 1'b0, 1'b0);         ecr = mcnt[2];
            if (vq[j].chk) begin
                eb = vq[j].eb; eg = vq[j].eg; er = vq[j].er;
                ecb = vq[j].cb; ecg = vq[j].cg; ecr = vq[j].cr;
            end
            check_eq($sformatf("sym_b[%0d]", j), int'(sb), int'(eb));
            check_eq($sformatf("sym_g[%0d]", j), int'(sg), int'(eg));
            check_eq($sformatf("sym_r[%0d]", j), int'(sr), int'(er));
            check_eq($sformatf("cnt_b[%0d]", j), cb, ecb);
            check_eq($sformatf("cnt_g[%0d]", j), cg, ecg);
            check_eq($sformatf("cnt_r[%0d]", j), cr, ecr);
            check_eq($sformatf("clk_pat[%0d]", j), int'(sc), 'h01F);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t d0, d1, d2;
        filler = mk(8'hA5, 8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 0, 0, 0);
        rst_n = 1'b0;
        drive(filler);
        repeat (5) @(negedge clk);
        check_eq("rst_out", int'({pix_strobe, tmds_b, tmds_g, tmds_r, tmds_clk}), 0);
        rst_n = 1'b1;

        d0 = mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0AB, 10'h354, 10'h354, 0, 0, 0);
        d1 = mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h100, 10'h100, 10'h100, -8, -8, -8);
        d2 = mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 2, 2, 2);
        vq.push_back(d0);
        vq.push_back(d1);
        vq.push_back(d2);
        vq.push_back(mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h100, 10'h100, 10'h100, -6, -6, -6));
        vq.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354, 0, 0, 0));
        vq.push_back(mk(8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 10'h200, 10'h100, 10'h100, -8, -8, -8));
        vq.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h154, 10'h354, 10'h354, 0, 0, 0));
        vq.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 10'h2AB, 10'h354, 10'h354, 0, 0, 0));
        vq.push_back(mk(8'hFF, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h100, 10'h133, 10'h200, -8, 0, -8));
        vq.push_back(mk(8'hFF, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF, 10'h133, 10'h0FF, 2, 0, -2));
        for (int n = 0; n < 256; n++) begin
            vq.push_back(mk(8'($urandom), 8'($urandom), 8'($urandom),
                            ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                            1'b0, '0, '0, '0, 0, 0, 0));
        end
        run_list();

        // Drop reset mid-symbol while data symbols are in flight.
        repeat (6) @(negedge clk);
        check_eq("mid_bitcnt", int'(dut.bit_cnt_q), 5);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_out", int'({pix_strobe, tmds_b, tmds_g, tmds_r, tmds_clk}), 0);
        check_eq("mid_rst_bitcnt", int'(dut.bit_cnt_q), 0);
        check_eq("mid_rst_cnt_b", int'($signed(dut.cnt_b_q)), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        vq.delete();
        vq.push_back(d1);
        vq.push_back(d2);
        vq.push_back(d0);
        run_list();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
